pixel_mem_arbiter: RTL

//  Shares one read-only image RAM (160x120, 3-bit pixels, 1-cycle registered read) between NUM_REQ pixel-walk engines.

---
 rtl/pixel_mem_arbiter_pkg.sv | 28 ++
 rtl/pixel_mem_arbiter_if.sv | 42 ++++
 rtl/pixel_mem_arbiter_rr_arbiter.sv | 44 ++++
 rtl/pixel_mem_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pixel_mem_arbiter_pkg.sv
// pixel_mem_pkg
//   Shared constants and helpers for the pixel memory arbiter.
//   Image geometry: 160x120 pixels, 3 bits per pixel, stored row-major.
//
//   xy_to_addr(x, y) : row-major address y*X_RES + x.
//                      Computed at ADDR_SZ width; overflow truncates.
package pixel_mem_pkg;

    localparam int X_RES   = 160;
    localparam int Y_RES   = 120;
    localparam int X_SZ    = 8;
    localparam int Y_SZ    = 7;
    localparam int ADDR_SZ = 15;
    localparam int COL_SZ  = 3;

    localparam logic [COL_SZ-1:0] BLACK_PIX = '0;

    // 160 = 128 + 32, so the multiply reduces to two shifts and an add.
    function automatic logic [ADDR_SZ-1:0] xy_to_addr(input logic [X_SZ-1:0] x,
                                                       input logic [Y_SZ-1:0] y);
        logic [ADDR_SZ-1:0] yWide;
        logic [ADDR_SZ-1:0] xWide;
        yWide = ADDR_SZ'(y);
        xWide = ADDR_SZ'(x);
        return (yWide << 7) + (yWide << 5) + xWide;
    endfunction

endpackage

// File: rtl/pixel_mem_arbiter_if.sv
// pixel_mem_if
//   Bundles the requester-facing handshake and the RAM-facing bus of the
//   pixel memory arbiter.
//
//   req         requester -> arb  per-requester read request
//   req_x       requester -> arb  packed x, slice i = requester i
//   req_y       requester -> arb  packed y, slice i = requester i
//   gnt         arb -> requester  one-hot grant, same cycle as req
//   rd_valid    arb -> requester  one-hot, pixel for requester i on rd_data
//   rd_data     arb -> requester  returned pixel (shared)
//   rd_oob      arb -> requester  returned read was out of range
//   mem_address arb -> RAM        registered read address
//   mem_q       RAM -> arb        read data, one cycle after mem_address
//
//   Modports: slave = arbiter side, master = requesters plus RAM side.
interface pixel_mem_if
    import pixel_mem_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*X_SZ-1:0] req_x;
    logic [NUM_REQ*Y_SZ-1:0] req_y;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      rd_valid;
    logic [COL_SZ-1:0]       rd_data;
    logic                    rd_oob;
    logic [ADDR_SZ-1:0]      mem_address;
    logic [COL_SZ-1:0]       mem_q;

    modport slave (
        input  req, req_x, req_y, mem_q,
        output gnt, rd_valid, rd_data, rd_oob, mem_address
    );

    modport master (
        output req, req_x, req_y, mem_q,
        input  gnt, rd_valid, rd_data, rd_oob, mem_address
    );

endinterface

// File: rtl/pixel_mem_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin grant: picks the first set req bit searching
//   from ptr upward with wrap-around.
//
//   req     in   NUM_REQ   request vector (already gated by the caller)
//   ptr     in   IDX_SZ    highest-priority requester index
//   gnt     out  NUM_REQ   one-hot grant, zero when req is zero
//   gntIdx  out  IDX_SZ    encoded index of the granted requester
//   anyGnt  out  1         a grant is being given this cycle
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_SZ  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_SZ-1:0]  ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_SZ-1:0]  gntIdx,
    output logic               anyGnt
);

    int                cand;
    logic [IDX_SZ-1:0] candIdx;

    always_comb begin
        gnt     = '0;
        gntIdx  = '0;
        anyGnt  = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = IDX_SZ'(cand);
            if (!anyGnt && req[candIdx]) begin
                anyGnt       = 1'b1;
                gnt[candIdx] = 1'b1;
                gntIdx       = candIdx;
            end
        end
    end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter
//   Shares one read-only image RAM (160x120, 3-bit pixels, 1-cycle
//   registered read) between NUM_REQ pixel-walk engines. Round-robin grant,
//   one read issued per cycle, fully pipelined; returned pixels are routed
//   back to the requester that won the grant two cycles earlier.
//
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high; discards in-flight reads
//   bus      slave side of pixel_mem_if (handshake, routing, RAM bus)
//
//   Optional feature macro: PIXEL_ARB_OOB_CHECK_EN
//     defined   : requests outside the image are granted but skip the RAM;
//                 they return BLACK_PIX with rd_oob=1.
//     undefined : no range check, rd_oob tied 0.
module pixel_mem_arbiter
    import pixel_mem_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic        clk,
    input  logic        reset,
    pixel_mem_if.slave  bus
);

    localparam int IDX_SZ = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] reqGated;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_SZ-1:0]  gntIdx;
    logic               transfer;

    logic [IDX_SZ-1:0]  ptr;
    logic [X_SZ-1:0]    selX;
    logic [Y_SZ-1:0]    selY;
    logic [ADDR_SZ-1:0] addrNext;
    logic               outOfRange;

    logic [ADDR_SZ-1:0] memAddress;
    logic               v1;
    logic               v2;
    logic [IDX_SZ-1:0]  tag1;
    logic [IDX_SZ-1:0]  tag2;
    logic               oob1;
    logic               oob2;
    logic [NUM_REQ-1:0] rdValid;

    // Nothing is granted while reset is held, so no transfer can slip in.
    assign reqGated = bus.req & {NUM_REQ{~reset}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_SZ  (IDX_SZ)
    ) uArb (
        .req    (reqGated),
        .ptr    (ptr),
        .gnt    (gnt),
        .gntIdx (gntIdx),
        .anyGnt (transfer)
    );

    assign bus.gnt = gnt;

    always_comb begin
        selX = '0;
        selY = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gntIdx == IDX_SZ'(k)) begin
                selX = bus.req_x[k*X_SZ +: X_SZ];
                selY = bus.req_y[k*Y_SZ +: Y_SZ];
            end
        end
    end

    assign addrNext = xy_to_addr(selX, selY);

`ifdef PIXEL_ARB_OOB_CHECK_EN
    assign outOfRange = (selX >= X_SZ'(X_RES)) || (selY >= Y_SZ'(Y_RES));
`else
    assign outOfRange = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            memAddress <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            tag1       <= '0;
            tag2       <= '0;
            oob1       <= 1'b0;
            oob2       <= 1'b0;
        end else begin
            v1   <= transfer;
            v2   <= v1;
            tag2 <= tag1;
            oob2 <= oob1;
            if (transfer) begin
                ptr  <= (int'(gntIdx) == NUM_REQ - 1) ? '0 : gntIdx + 1'b1;
                tag1 <= gntIdx;
                oob1 <= outOfRange;
                // Out-of-range reads never touch the RAM; the address bus
                // keeps its previous value.
                if (!outOfRange) begin
                    memAddress <= addrNext;
                end
            end
        end
    end

    assign bus.mem_address = memAddress;

    always_comb begin
        rdValid = '0;
        if (v2) begin
            rdValid[tag2] = 1'b1;
        end
    end

    assign bus.rd_valid = rdValid;
    assign bus.rd_data  = (v2 && !oob2) ? bus.mem_q : BLACK_PIX;

`ifdef PIXEL_ARB_OOB_CHECK_EN
    assign bus.rd_oob = v2 & oob2;
`else
    assign bus.rd_oob = 1'b0;
`endif

endmodule
